// File: rtl/axi_lite_apb_multi_bridge.sv
// axi_lite_apb_multi_bridge: AXI4-Lite slave to multi-slave APB bridge, one outstanding transfer, round-robin R/W grant
module axi_lite_apb_multi_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS        = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLAVE_ASIZE    = 12,
  parameter logic [ADDRESS-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [ADDRESS-1:0]               S_AWADDR,
  input  logic                             S_AWVALID,
  output logic                             S_AWREADY,
  input  logic [DATA_WIDTH-1:0]            S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]          S_WSTRB,
  input  logic                             S_WVALID,
  output logic                             S_WREADY,
  output logic [1:0]                       S_BRESP,
  output logic                             S_BVALID,
  input  logic                             S_BREADY,
  input  logic [ADDRESS-1:0]               S_ARADDR,
  input  logic                             S_ARVALID,
  output logic                             S_ARREADY,
  output logic [DATA_WIDTH-1:0]            S_RDATA,
  output logic [1:0]                       S_RRESP,
  output logic                             S_RVALID,
  input  logic                             S_RREADY,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDRESS-1:0]               PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRESP, RRESP} state_t;
  state_t state_q, state_d;
  logic aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [ADDRESS-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d, paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [SW-1:0] w_strb_q, w_strb_d, pstrb_q, pstrb_d;
  logic last_w_q, last_w_d, pwrite_q, pwrite_d, penable_q, penable_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic w_pend, r_pend, gw, bad, done, tmo, free_w, free_r;
  logic [ADDRESS-1:0] addr, idx_full;
  logic [1:0] resp;
  assign w_pend   = aw_full_q && w_full_q;
  assign r_pend   = ar_full_q;
  assign gw       = w_pend && (!r_pend || !last_w_q);
  assign addr     = gw ? aw_addr_q : ar_addr_q;
  assign idx_full = (addr - BASE_ADDR) >> SLAVE_ASIZE;
  assign bad      = (addr < BASE_ADDR) || (idx_full >= ADDRESS'(NUM_SLAVES));
  assign done     = PREADY[idx_q];
  assign tmo      = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign resp     = done ? (PSLVERR[idx_q] ? 2'b10 : 2'b00) : 2'b10;
  assign S_AWREADY = !aw_full_q;
  assign S_WREADY  = !w_full_q;
  assign S_ARREADY = !ar_full_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_RVALID  = rvalid_q;
  assign S_RRESP   = rresp_q;
  assign S_RDATA   = rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  // Transfer FSM: grant, decode, APB sequencing, timeout and AXI response generation
  always_comb begin
    state_d   = state_q;
    last_w_d  = last_w_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    free_w    = 1'b0;
    free_r    = 1'b0;
    case (state_q)
      IDLE: if (w_pend || r_pend) begin
        last_w_d = gw;
        pwrite_d = gw;
        paddr_d  = addr;
        pwdata_d = gw ? w_data_q : '0;
        pstrb_d  = gw ? w_strb_q : '0;
        idx_d    = idx_full[IW-1:0];
        if (bad) begin
          free_w   = gw;
          free_r   = !gw;
          bvalid_d = gw;
          bresp_d  = gw ? 2'b11 : bresp_q;
          rvalid_d = !gw;
          rresp_d  = gw ? rresp_q : 2'b11;
          rdata_d  = gw ? rdata_q : '0;
          state_d  = gw ? WRESP : RRESP;
        end else begin
          psel_d  = NUM_SLAVES'(1) << idx_full[IW-1:0];
          state_d = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: if (done || tmo) begin
        psel_d    = '0;
        penable_d = 1'b0;
        free_w    = pwrite_q;
        free_r    = !pwrite_q;
        bvalid_d  = pwrite_q;
        bresp_d   = pwrite_q ? resp : bresp_q;
        rvalid_d  = !pwrite_q;
        rresp_d   = pwrite_q ? rresp_q : resp;
        rdata_d   = pwrite_q ? rdata_q : (done ? PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0);
        state_d   = pwrite_q ? WRESP : RRESP;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      WRESP: if (S_BREADY) begin
        bvalid_d = 1'b0;
        state_d  = IDLE;
      end
      RRESP: if (S_RREADY) begin
        rvalid_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Holding registers: accept while empty, release when the granted transfer finishes
  always_comb begin
    aw_full_d = aw_full_q ? !free_w : S_AWVALID;
    w_full_d  = w_full_q ? !free_w : S_WVALID;
    ar_full_d = ar_full_q ? !free_r : S_ARVALID;
    aw_addr_d = (!aw_full_q && S_AWVALID) ? S_AWADDR : aw_addr_q;
    w_data_d  = (!w_full_q && S_WVALID) ? S_WDATA : w_data_q;
    w_strb_d  = (!w_full_q && S_WVALID) ? S_WSTRB : w_strb_q;
    ar_addr_d = (!ar_full_q && S_ARVALID) ? S_ARADDR : ar_addr_q;
  end
  // State and output registers with synchronous reset that drops any in-flight transfer
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      last_w_q  <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_addr_q <= ar_addr_d;
      last_w_q  <= last_w_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_apb_multi_bridge.sv
// tb_axi_lite_apb_multi_bridge: directed bench for the AXI-Lite to APB bridge with a wait-state slave model
module tb_axi_lite_apb_multi_bridge;
  logic ACLK, ARESET;
  logic [31:0] S_AWADDR, S_WDATA, S_ARADDR, S_RDATA, PADDR, PWDATA;
  logic [3:0] S_WSTRB, PSTRB, PSEL, PREADY, PSLVERR;
  logic S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic S_ARVALID, S_ARREADY, S_RVALID, S_RREADY, PENABLE, PWRITE;
  logic [1:0] S_BRESP, S_RRESP;
  logic [127:0] PRDATA;
  int ws [4];
  logic [31:0] rd [4];
  int acc;
  int vectors = 0, errors = 0;
  logic [1:0] resp;
  logic [31:0] rdat;
  int pen, n, awn, wn, arn;
  logic [3:0] sel;
  logic a, w, r;
  logic order [4];

  axi_lite_apb_multi_bridge #(.DATA_WIDTH(32), .ADDRESS(32), .NUM_SLAVES(4), .SLAVE_ASIZE(12),
    .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  assign PRDATA = {rd[3], rd[2], rd[1], rd[0]};
  for (genvar g = 0; g < 4; g++) begin : g_slv
    assign PREADY[g] = PSEL[g] && PENABLE && (acc >= ws[g]);
  end
  always @(posedge ACLK) acc <= PENABLE ? acc + 1 : 0;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output logic [1:0] rsp, output logic [31:0] rdo,
                     output int pc, output logic [3:0] sl);
    logic ha, hw, hr, got;
    rsp = 'x; rdo = 'x; pc = 0; sl = '0; got = 1'b0;
    if (wr) begin
      S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb; S_AWVALID = 1'b1; S_WVALID = 1'b1;
    end else begin
      S_ARADDR = addr; S_ARVALID = 1'b1;
    end
    for (int i = 0; i < 50 && (S_AWVALID || S_WVALID || S_ARVALID); i++) begin
      ha = S_AWVALID && S_AWREADY; hw = S_WVALID && S_WREADY; hr = S_ARVALID && S_ARREADY;
      step();
      if (ha) S_AWVALID = 1'b0;
      if (hw) S_WVALID = 1'b0;
      if (hr) S_ARVALID = 1'b0;
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (wr ? S_BVALID : S_RVALID) begin
        got = 1'b1;
        break;
      end
      if (PENABLE) pc++;
      sl |= PSEL;
      step();
    end
    if (got) begin
      rsp = wr ? S_BRESP : S_RRESP;
      rdo = S_RDATA;
      S_BREADY = wr; S_RREADY = !wr;
      step();
      S_BREADY = 1'b0; S_RREADY = 1'b0;
    end
  endtask

  initial begin
    ARESET = 1'b1;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0; PSLVERR = '0;
    for (int i = 0; i < 4; i++) begin
      ws[i] = 0;
      rd[i] = 32'hC0DE_0000 + 32'(i);
    end
    repeat (3) step();
    ARESET = 1'b0;
    chk("rst_awready", S_AWREADY, 1); chk("rst_wready", S_WREADY, 1);
    chk("rst_arready", S_ARREADY, 1); chk("rst_bvalid", S_BVALID, 0);
    chk("rst_rvalid", S_RVALID, 0);   chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    step();
    // write 0xDEADBEEF to 0x1004, cycle-exact
    S_AWADDR = 32'h1004; S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'hF; S_AWVALID = 1'b1; S_WVALID = 1'b1;
    step();
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    chk("w1_e0_psel", PSEL, 0);
    chk("w1_e0_awready", S_AWREADY, 0);
    step();
    chk("w1_setup_psel", PSEL, 4'b0010); chk("w1_setup_penable", PENABLE, 0);
    chk("w1_paddr", PADDR, 32'h1004);    chk("w1_pstrb", PSTRB, 4'hF);
    chk("w1_pwdata", PWDATA, 32'hDEADBEEF); chk("w1_pwrite", PWRITE, 1);
    step();
    chk("w1_access_penable", PENABLE, 1); chk("w1_access_psel", PSEL, 4'b0010);
    step();
    chk("w1_bvalid", S_BVALID, 1); chk("w1_bresp", S_BRESP, 2'b00);
    chk("w1_psel_drop", PSEL, 0);  chk("w1_penable_drop", PENABLE, 0);
    chk("w1_awready_free", S_AWREADY, 1);
    S_BREADY = 1'b1;
    step();
    S_BREADY = 1'b0;
    chk("w1_bvalid_clr", S_BVALID, 0);
    // read 0x3010, slave 3 with two wait states and PSLVERR
    ws[3] = 2; rd[3] = 32'h12345678; PSLVERR = 4'b1000;
    txn(1'b0, 32'h3010, 32'h0, 4'h0, resp, rdat, pen, sel);
    chk("r3_rdata", rdat, 32'h12345678); chk("r3_rresp", resp, 2'b10);
    chk("r3_penable_cycles", pen, 3);    chk("r3_psel", sel, 4'b1000);
    PSLVERR = '0; ws[3] = 0;
    // read outside all windows
    txn(1'b0, 32'h5000, 32'h0, 4'h0, resp, rdat, pen, sel);
    chk("dec_rresp", resp, 2'b11); chk("dec_rdata", rdat, 0);
    chk("dec_psel", sel, 0);       chk("dec_penable", pen, 0);
    // reads and writes both pending: round robin
    S_AWADDR = 32'h0000; S_WDATA = 32'hA5A5A5A5; S_WSTRB = 4'hF; S_ARADDR = 32'h2000;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1; S_BREADY = 1'b1; S_RREADY = 1'b1;
    n = 0; awn = 0; wn = 0; arn = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      a = S_AWVALID && S_AWREADY; w = S_WVALID && S_WREADY; r = S_ARVALID && S_ARREADY;
      if (PSEL != 0 && !PENABLE) begin
        order[n] = PWRITE;
        n++;
      end
      step();
      if (a) begin awn++; if (awn == 2) S_AWVALID = 1'b0; end
      if (w) begin wn++;  if (wn == 2)  S_WVALID = 1'b0; end
      if (r) begin arn++; if (arn == 2) S_ARVALID = 1'b0; end
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    chk("rr_count", n, 4);
    chk("rr_0", order[0], 1); chk("rr_1", order[1], 0);
    chk("rr_2", order[2], 1); chk("rr_3", order[3], 0);
    repeat (10) step();
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    chk("rr_idle_bvalid", S_BVALID, 0); chk("rr_idle_rvalid", S_RVALID, 0);
    // slave 0 hangs: timeout after 8 access cycles
    ws[0] = 1000;
    txn(1'b1, 32'h0008, 32'h11112222, 4'h3, resp, rdat, pen, sel);
    chk("to_bresp", resp, 2'b10); chk("to_penable_cycles", pen, 8); chk("to_psel", sel, 4'b0001);
    ws[0] = 0;
    txn(1'b1, 32'h0008, 32'h11112222, 4'h3, resp, rdat, pen, sel);
    chk("after_to_bresp", resp, 2'b00); chk("after_to_penable_cycles", pen, 1);
    // reset during ACCESS with no response taken
    ws[1] = 1000;
    S_AWADDR = 32'h1000; S_WDATA = 32'h5; S_WSTRB = 4'h0; S_AWVALID = 1'b1; S_WVALID = 1'b1;
    step();
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    step();
    chk("rst_mid_pstrb_zero", PSTRB, 4'h0);
    step();
    chk("rst_mid_in_access", PENABLE, 1);
    step();
    ARESET = 1'b1;
    step();
    chk("rst_mid_psel", PSEL, 0);       chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_bvalid", S_BVALID, 0); chk("rst_mid_awready", S_AWREADY, 1);
    chk("rst_mid_wready", S_WREADY, 1); chk("rst_mid_arready", S_ARREADY, 1);
    ARESET = 1'b0; ws[1] = 0;
    step();
    txn(1'b1, 32'h1000, 32'h6, 4'hF, resp, rdat, pen, sel);
    chk("post_rst_bresp", resp, 2'b00); chk("post_rst_psel", sel, 4'b0010);
    chk("post_rst_penable_cycles", pen, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
